// File: rtl/clint_pkg.sv
// clint_pkg: shared FSM state type and AXI constants for the CLINT request arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clint_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RESP
   } clint_state_e;

   localparam logic [63:0] CLINT_BASE_DEFAULT = 64'h0200_0000;

   // Every CLINT access is a single 64-bit beat.
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [7:0] AXI_STRB_ALL   = 8'hFF;

   // Index width that stays legal for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clint_req_arbiter_if.sv
// clint_req_arbiter_if: single-ID AXI4 channel bundle between the CLINT arbiter (master) and the bus (slave).
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on every channel.
interface clint_req_arbiter_if #(
   parameter int ID_WIDTH = 4
);
   logic                aw_valid;
   logic                aw_ready;
   logic [ID_WIDTH-1:0] aw_id;
   logic [63:0]         aw_addr;
   logic [7:0]          aw_len;
   logic [2:0]          aw_size;
   logic [1:0]          aw_burst;

   logic                w_valid;
   logic                w_ready;
   logic [63:0]         w_data;
   logic [7:0]          w_strb;
   logic                w_last;

   logic                b_valid;
   logic                b_ready;
   logic [1:0]          b_resp;

   logic                ar_valid;
   logic                ar_ready;
   logic [ID_WIDTH-1:0] ar_id;
   logic [63:0]         ar_addr;
   logic [7:0]          ar_len;
   logic [2:0]          ar_size;
   logic [1:0]          ar_burst;

   logic                r_valid;
   logic                r_ready;
   logic [63:0]         r_data;
   logic [1:0]          r_resp;
   logic                r_last;

   modport master (
      output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
      output w_valid, w_data, w_strb, w_last,
      output b_ready,
      output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
      output r_ready,
      input  aw_ready, w_ready, b_valid, b_resp,
      input  ar_ready, r_valid, r_data, r_resp, r_last
   );

   modport slave (
      input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
      input  w_valid, w_data, w_strb, w_last,
      input  b_ready,
      input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
      input  r_ready,
      output aw_ready, w_ready, b_valid, b_resp,
      output ar_ready, r_valid, r_data, r_resp, r_last
   );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr_i and wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: req_i request vector, ptr_i first index to consider, gnt_o one-hot grant, idx_o granted index.
module rr_arbiter import clint_pkg::*; #(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o
);
   // One spare bit so ptr + i cannot overflow before the wrap.
   localparam int SW = IDX_W + 1;

   logic [SW-1:0] cand;
   logic          found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr_i} + SW'(i);
         if (cand >= SW'(N)) begin
            cand = cand - SW'(N);
         end
         if (!found && req_i[cand[IDX_W-1:0]]) begin
            found                  = 1'b1;
            gnt_o[cand[IDX_W-1:0]] = 1'b1;
            idx_o                  = cand[IDX_W-1:0];
         end
      end
   end
endmodule

// File: rtl/clint_req_arbiter.sv
// clint_req_arbiter: round-robin funnel of per-core CLINT accesses onto one single-beat AXI4 master.
// Latency: grant cycle, then AW/W or AR, then B or R, then a one-cycle resp pulse (write with ready slave: resp 3 cycles after grant).
// Backpressure: one transaction in flight; other requests wait (req_ready_o low) until the FSM is back in IDLE.
// Ports: clk/ndmreset_n; per-core req_valid_i/req_ready_o/req_we_i/req_off_i/req_wdata_i;
//        resp_valid_o (per core), resp_rdata_o/resp_err_o (shared); axi master modport.
module clint_req_arbiter import clint_pkg::*; #(
   parameter int          NR_CORES   = 2,
   parameter int          ID_WIDTH   = 4,
   parameter logic [63:0] CLINT_BASE = CLINT_BASE_DEFAULT
) (
   input  logic                      clk,
   input  logic                      ndmreset_n,
   input  logic [NR_CORES-1:0]       req_valid_i,
   output logic [NR_CORES-1:0]       req_ready_o,
   input  logic [NR_CORES-1:0]       req_we_i,
   input  logic [NR_CORES-1:0][15:0] req_off_i,
   input  logic [NR_CORES-1:0][63:0] req_wdata_i,
   output logic [NR_CORES-1:0]       resp_valid_o,
   output logic [63:0]               resp_rdata_o,
   output logic                      resp_err_o,
   clint_req_arbiter_if.master       axi
);
   localparam int IDX_W = idx_width(NR_CORES);

   clint_state_e        state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [15:0]         off_q, off_d;
   logic [63:0]         wdata_q, wdata_d;
   logic [63:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                aw_valid_q, aw_valid_d;
   logic                w_valid_q, w_valid_d;
   logic                ar_valid_q, ar_valid_d;
   logic                b_ready_q, b_ready_d;
   logic                r_ready_q, r_ready_d;
   logic [NR_CORES-1:0] resp_valid_q, resp_valid_d;

   logic [NR_CORES-1:0] arb_gnt;
   logic [IDX_W-1:0]    arb_idx;
   logic [63:0]         addr;

   rr_arbiter #(
      .N     (NR_CORES),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   // Ready is the acceptance strobe, so it must be combinational in the grant
   // cycle; gating with the reset keeps it low while the core is held in reset.
   assign req_ready_o = (state_q == IDLE && ndmreset_n) ? arb_gnt : '0;

   assign addr = CLINT_BASE + {48'h0, off_q};

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      idx_d        = idx_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      aw_valid_d   = aw_valid_q;
      w_valid_d    = w_valid_q;
      ar_valid_d   = ar_valid_q;
      b_ready_d    = b_ready_q;
      r_ready_d    = r_ready_q;
      resp_valid_d = '0;

      unique case (state_q)
         IDLE: begin
            if (|req_valid_i) begin
               idx_d   = arb_idx;
               off_d   = req_off_i[arb_idx];
               wdata_d = req_wdata_i[arb_idx];
               rdata_d = '0;
               err_d   = 1'b0;
               ptr_d   = (arb_idx == IDX_W'(NR_CORES - 1)) ? '0 : arb_idx + IDX_W'(1);
               if (req_we_i[arb_idx]) begin
                  state_d    = WR_ADDR_DATA;
                  aw_valid_d = 1'b1;
                  w_valid_d  = 1'b1;
               end else begin
                  state_d    = RD_ADDR;
                  ar_valid_d = 1'b1;
               end
            end
         end
         WR_ADDR_DATA: begin
            // AW and W retire independently; leave once neither is still pending.
            if (axi.aw_ready) aw_valid_d = 1'b0;
            if (axi.w_ready)  w_valid_d  = 1'b0;
            if ((!aw_valid_q || axi.aw_ready) && (!w_valid_q || axi.w_ready)) begin
               state_d   = WR_RESP;
               b_ready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (axi.b_valid) begin
               err_d        = (axi.b_resp != 2'b00);
               b_ready_d    = 1'b0;
               resp_valid_d = NR_CORES'(1) << idx_q;
               state_d      = RESP;
            end
         end
         RD_ADDR: begin
            if (axi.ar_ready) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = RD_DATA;
            end
         end
         RD_DATA: begin
            if (axi.r_valid) begin
               rdata_d      = axi.r_data;
               // A single-beat read that is not marked last is treated as broken.
               err_d        = (axi.r_resp != 2'b00) || !axi.r_last;
               r_ready_d    = 1'b0;
               resp_valid_d = NR_CORES'(1) << idx_q;
               state_d      = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge ndmreset_n) begin
      if (!ndmreset_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         idx_q        <= '0;
         off_q        <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         aw_valid_q   <= 1'b0;
         w_valid_q    <= 1'b0;
         ar_valid_q   <= 1'b0;
         b_ready_q    <= 1'b0;
         r_ready_q    <= 1'b0;
         resp_valid_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         off_q        <= off_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         aw_valid_q   <= aw_valid_d;
         w_valid_q    <= w_valid_d;
         ar_valid_q   <= ar_valid_d;
         b_ready_q    <= b_ready_d;
         r_ready_q    <= r_ready_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   // Address/ID come from latched state, so they hold steady under backpressure.
   assign axi.aw_valid = aw_valid_q;
   assign axi.aw_id    = ID_WIDTH'(idx_q);
   assign axi.aw_addr  = addr;
   assign axi.aw_len   = AXI_LEN_SINGLE;
   assign axi.aw_size  = AXI_SIZE_8B;
   assign axi.aw_burst = AXI_BURST_INCR;
   assign axi.w_valid  = w_valid_q;
   assign axi.w_data   = wdata_q;
   assign axi.w_strb   = AXI_STRB_ALL;
   assign axi.w_last   = 1'b1;
   assign axi.b_ready  = b_ready_q;
   assign axi.ar_valid = ar_valid_q;
   assign axi.ar_id    = ID_WIDTH'(idx_q);
   assign axi.ar_addr  = addr;
   assign axi.ar_len   = AXI_LEN_SINGLE;
   assign axi.ar_size  = AXI_SIZE_8B;
   assign axi.ar_burst = AXI_BURST_INCR;
   assign axi.r_ready  = r_ready_q;

   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;
endmodule

// File: tb/tb_clint_req_arbiter.sv
// tb_clint_req_arbiter: directed scenarios for the two-core CLINT arbiter with a hand-driven AXI slave.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 2 units after posedge.
// Backpressure: slave ready/valid timing is set explicitly per scenario.
module tb_clint_req_arbiter;
   logic             clk = 1'b0;
   logic             ndmreset_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready_o;
   logic [1:0]       req_we;
   logic [1:0][15:0] req_off;
   logic [1:0][63:0] req_wdata;
   logic [1:0]       resp_valid_o;
   logic [63:0]      resp_rdata_o;
   logic             resp_err_o;

   int checks = 0;
   int errors = 0;

   clint_req_arbiter_if #(.ID_WIDTH(4)) axi ();

   clint_req_arbiter #(
      .NR_CORES   (2),
      .ID_WIDTH   (4),
      .CLINT_BASE (64'h0200_0000)
   ) dut (
      .clk          (clk),
      .ndmreset_n   (ndmreset_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready_o),
      .req_we_i     (req_we),
      .req_off_i    (req_off),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid_o),
      .resp_rdata_o (resp_rdata_o),
      .resp_err_o   (resp_err_o),
      .axi          (axi)
   );

   always #5 clk = ~clk;

   task automatic clear_slave();
      axi.aw_ready = 1'b0;
      axi.w_ready  = 1'b0;
      axi.b_valid  = 1'b0;
      axi.b_resp   = 2'b00;
      axi.ar_ready = 1'b0;
      axi.r_valid  = 1'b0;
      axi.r_data   = 64'h0;
      axi.r_resp   = 2'b00;
      axi.r_last   = 1'b0;
   endtask

   task automatic test_reset();
      ndmreset_n = 1'b0;
      req_valid  = 2'b11;
      req_we     = 2'b11;
      req_off    = '0;
      req_wdata  = '0;
      clear_slave();
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (req_ready_o !== 2'b00) begin
         errors++; $display("FAIL rst_req_ready: got %b expected %b", req_ready_o, 2'b00);
      end
      checks++;
      if ({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready} !== 5'b0) begin
         errors++; $display("FAIL rst_axi_valids: got %b expected %b",
            {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 5'b0);
      end
      checks++;
      if ({resp_valid_o, resp_err_o, resp_rdata_o} !== 67'b0) begin
         errors++; $display("FAIL rst_resp: valid %b err %b rdata %h expected all zero",
            resp_valid_o, resp_err_o, resp_rdata_o);
      end
      req_valid = 2'b00;
      @(posedge clk); #1;
      ndmreset_n = 1'b1;
   endtask

   task automatic test_write_basic();
      @(posedge clk); #1;
      req_valid = 2'b01; req_we = 2'b01; req_off[0] = 16'h4000; req_wdata[0] = 64'h1234;
      axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b1; axi.b_resp = 2'b00;
      #1;
      checks++;
      if (req_ready_o !== 2'b01) begin
         errors++; $display("FAIL wr_grant: got %b expected %b", req_ready_o, 2'b01);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      checks++;
      if ({axi.aw_valid, axi.w_valid} !== 2'b11) begin
         errors++; $display("FAIL wr_aw_w_valid: got %b expected %b", {axi.aw_valid, axi.w_valid}, 2'b11);
      end
      checks++;
      if (axi.aw_addr !== 64'h0000_0000_0200_4000 || axi.aw_id !== 4'd0) begin
         errors++; $display("FAIL wr_addr_id: addr %h id %0d expected addr %h id 0",
            axi.aw_addr, axi.aw_id, 64'h0200_4000);
      end
      checks++;
      if ({axi.aw_len, axi.aw_size, axi.aw_burst, axi.w_strb, axi.w_last, axi.w_data}
          !== {8'd0, 3'b011, 2'b01, 8'hFF, 1'b1, 64'h1234}) begin
         errors++; $display("FAIL wr_beat_fields: len %0d size %b burst %b strb %h last %b data %h",
            axi.aw_len, axi.aw_size, axi.aw_burst, axi.w_strb, axi.w_last, axi.w_data);
      end
      @(posedge clk); #2;
      checks++;
      if ({axi.b_ready, axi.aw_valid, axi.w_valid, resp_valid_o} !== 5'b10000) begin
         errors++; $display("FAIL wr_resp_phase: b_ready/aw/w/resp got %b expected %b",
            {axi.b_ready, axi.aw_valid, axi.w_valid, resp_valid_o}, 5'b10000);
      end
      @(posedge clk); #1;
      clear_slave();
      #1;
      checks++;
      if (resp_valid_o !== 2'b01 || resp_err_o !== 1'b0 || resp_rdata_o !== 64'h0) begin
         errors++; $display("FAIL wr_resp: valid %b err %b rdata %h expected 01 0 0",
            resp_valid_o, resp_err_o, resp_rdata_o);
      end
      @(posedge clk); #2;
      checks++;
      if (resp_valid_o !== 2'b00) begin
         errors++; $display("FAIL wr_resp_pulse: got %b expected %b", resp_valid_o, 2'b00);
      end
   endtask

   task automatic test_read_basic();
      @(posedge clk); #1;
      req_valid = 2'b10; req_we = 2'b00; req_off[1] = 16'hBFF8;
      axi.ar_ready = 1'b1; axi.r_valid = 1'b1; axi.r_data = 64'hDEAD;
      axi.r_resp = 2'b00; axi.r_last = 1'b1;
      #1;
      checks++;
      if (req_ready_o !== 2'b10) begin
         errors++; $display("FAIL rd_grant: got %b expected %b", req_ready_o, 2'b10);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      checks++;
      if (axi.ar_valid !== 1'b1 || axi.ar_addr !== 64'h0000_0000_0200_BFF8 || axi.ar_id !== 4'd1) begin
         errors++; $display("FAIL rd_ar: valid %b addr %h id %0d expected 1 %h 1",
            axi.ar_valid, axi.ar_addr, axi.ar_id, 64'h0200_BFF8);
      end
      @(posedge clk); #2;
      checks++;
      if ({axi.r_ready, axi.ar_valid} !== 2'b10) begin
         errors++; $display("FAIL rd_data_phase: r_ready/ar_valid got %b expected %b",
            {axi.r_ready, axi.ar_valid}, 2'b10);
      end
      @(posedge clk); #1;
      clear_slave();
      #1;
      checks++;
      if (resp_valid_o !== 2'b10 || resp_rdata_o !== 64'hDEAD || resp_err_o !== 1'b0) begin
         errors++; $display("FAIL rd_resp: valid %b rdata %h err %b expected 10 dead 0",
            resp_valid_o, resp_rdata_o, resp_err_o);
      end
      @(posedge clk); #2;
   endtask

   task automatic test_round_robin();
      logic [1:0] g;
      logic [1:0] exp_g;
      bit         got;
      @(posedge clk); #1;
      req_valid = 2'b11; req_we = 2'b11;
      axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b1; axi.b_resp = 2'b00;
      for (int t = 0; t < 4; t++) begin
         got   = 1'b0;
         g     = 2'b00;
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready_o != 2'b00) begin
               got = 1'b1;
               g   = req_ready_o;
            end
            @(posedge clk); #1;
         end
         checks++;
         if (g !== exp_g) begin
            errors++; $display("FAIL rr_grant%0d: got %b expected %b", t, g, exp_g);
         end
      end
      req_valid = 2'b00;
      repeat (5) @(posedge clk);
      #1;
      clear_slave();
   endtask

   task automatic test_split_write();
      @(posedge clk); #1;
      req_valid = 2'b01; req_we = 2'b01; req_off[0] = 16'h0010; req_wdata[0] = 64'hA5A5;
      axi.aw_ready = 1'b1; axi.w_ready = 1'b0; axi.b_valid = 1'b0;
      #1;
      checks++;
      if (req_ready_o !== 2'b01) begin
         errors++; $display("FAIL split_grant: got %b expected %b", req_ready_o, 2'b01);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      #1;
      checks++;
      if ({axi.aw_valid, axi.w_valid} !== 2'b11) begin
         errors++; $display("FAIL split_t1: aw/w got %b expected %b", {axi.aw_valid, axi.w_valid}, 2'b11);
      end
      for (int c = 2; c <= 3; c++) begin
         @(posedge clk); #1;
         axi.aw_ready = 1'b0;
         #1;
         checks++;
         if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== 3'b010) begin
            errors++; $display("FAIL split_t%0d: aw/w/b_ready got %b expected %b",
               c, {axi.aw_valid, axi.w_valid, axi.b_ready}, 3'b010);
         end
         checks++;
         if (axi.aw_addr !== 64'h0000_0000_0200_0010 || axi.w_data !== 64'hA5A5) begin
            errors++; $display("FAIL split_stable_t%0d: addr %h data %h expected %h a5a5",
               c, axi.aw_addr, axi.w_data, 64'h0200_0010);
         end
      end
      @(posedge clk); #1;
      axi.w_ready = 1'b1;
      #1;
      checks++;
      if ({axi.w_valid, axi.b_ready} !== 2'b10) begin
         errors++; $display("FAIL split_t4: w/b_ready got %b expected %b", {axi.w_valid, axi.b_ready}, 2'b10);
      end
      @(posedge clk); #1;
      axi.w_ready = 1'b0;
      axi.b_valid = 1'b1;
      #1;
      checks++;
      if ({axi.w_valid, axi.b_ready} !== 2'b01) begin
         errors++; $display("FAIL split_t5: w/b_ready got %b expected %b", {axi.w_valid, axi.b_ready}, 2'b01);
      end
      @(posedge clk); #1;
      axi.b_valid = 1'b0;
      #1;
      checks++;
      if ({axi.b_ready, resp_valid_o, resp_err_o} !== 4'b0010) begin
         errors++; $display("FAIL split_t6: b_ready/resp/err got %b expected %b",
            {axi.b_ready, resp_valid_o, resp_err_o}, 4'b0010);
      end
      @(posedge clk); #2;
   endtask

   task automatic test_errors();
      // Write to core1 answered with SLVERR.
      @(posedge clk); #1;
      req_valid = 2'b10; req_we = 2'b10; req_off[1] = 16'h0008;
      axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b1; axi.b_resp = 2'b10;
      #1;
      checks++;
      if (req_ready_o !== 2'b10) begin
         errors++; $display("FAIL werr_grant: got %b expected %b", req_ready_o, 2'b10);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (resp_valid_o !== 2'b10 || resp_err_o !== 1'b1) begin
         errors++; $display("FAIL werr_resp: valid %b err %b expected 10 1", resp_valid_o, resp_err_o);
      end
      @(posedge clk); #1;
      clear_slave();
      // Read on core0 where the only beat lacks r_last.
      @(posedge clk); #1;
      req_valid = 2'b01; req_we = 2'b00; req_off[0] = 16'h0000;
      axi.ar_ready = 1'b1; axi.r_valid = 1'b1; axi.r_data = 64'h55;
      axi.r_resp = 2'b00; axi.r_last = 1'b0;
      #1;
      checks++;
      if (req_ready_o !== 2'b01) begin
         errors++; $display("FAIL rerr_grant: got %b expected %b", req_ready_o, 2'b01);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (resp_valid_o !== 2'b01 || resp_err_o !== 1'b1 || resp_rdata_o !== 64'h55) begin
         errors++; $display("FAIL rerr_resp: valid %b err %b rdata %h expected 01 1 55",
            resp_valid_o, resp_err_o, resp_rdata_o);
      end
      @(posedge clk); #1;
      clear_slave();
   endtask

   task automatic test_reset_mid();
      int pulses;
      int breadys;
      pulses  = 0;
      breadys = 0;
      @(posedge clk); #1;
      req_valid = 2'b10; req_we = 2'b10; req_off[1] = 16'h0020;
      axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b0;
      #1;
      checks++;
      if (req_ready_o !== 2'b10) begin
         errors++; $display("FAIL rstmid_grant: got %b expected %b", req_ready_o, 2'b10);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #2;
      checks++;
      if (axi.b_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_in_wr_resp: b_ready got %b expected 1", axi.b_ready);
      end
      #1;
      ndmreset_n  = 1'b0;
      axi.b_valid = 1'b1;
      #1;
      checks++;
      if ({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, resp_valid_o, req_ready_o}
          !== 9'b0) begin
         errors++; $display("FAIL rstmid_valids: got %b expected all zero",
            {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready, resp_valid_o, req_ready_o});
      end
      @(posedge clk); #1;
      ndmreset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #2;
         if (resp_valid_o != 2'b00) pulses++;
         if (axi.b_ready) breadys++;
      end
      checks++;
      if (pulses !== 0 || breadys !== 0) begin
         errors++; $display("FAIL rstmid_no_completion: resp pulses %0d b_ready cycles %0d expected 0 0",
            pulses, breadys);
      end
      #1;
      axi.b_valid = 1'b0;
      req_valid = 2'b11; req_we = 2'b00;
      #1;
      checks++;
      if (req_ready_o !== 2'b01) begin
         errors++; $display("FAIL rstmid_next_grant: got %b expected %b", req_ready_o, 2'b01);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_round_robin();
      test_split_write();
      test_errors();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/clint_req_arbiter.md
CLINT_REQ_ARBITER -- requirements
Module: clint_req_arbiter

Interface
REQ-001 SHALL have parameter NR_CORES, default 2, number of requesters (1..16).
REQ-002 SHALL have parameter ID_WIDTH, default 4, AXI ID width; requester index is placed in the ID.
REQ-003 SHALL have parameter CLINT_BASE, default 64'h0200_0000, base address added to each requester offset.
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port ndmreset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid_i, input, NR_CORES, per-core request valid.
REQ-007 SHALL have port req_ready_o, output, NR_CORES, per-core request accepted.
REQ-008 SHALL have ports req_we_i (NR_CORES x1), req_off_i (NR_CORES x16) and req_wdata_i (NR_CORES x64), all inputs: write flag, byte offset and write data.
REQ-009 SHALL have ports resp_valid_o (NR_CORES, output), resp_rdata_o (64, output, shared) and resp_err_o (1, output, shared).
REQ-010 SHALL have AXI master outputs aw/ar valid, id (ID_WIDTH), addr (64), len (8), size (3) and burst (2); w valid, data (64), strb (8) and last; b_ready; r_ready.
REQ-011 SHALL have AXI inputs aw_ready, w_ready, ar_ready, b_valid, b_resp (2), r_valid, r_data (64), r_resp (2) and r_last.

Function
REQ-012 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and RESP.
REQ-013 In IDLE with any req_valid_i set, SHALL grant exactly one core by round-robin, starting at the index after the last granted core (index 0 after reset).
REQ-014 SHALL pulse req_ready_o of the granted core for exactly one cycle, in the grant cycle, and latch that core's we, off and wdata.
REQ-015 SHALL enter WR_ADDR_DATA if the latched we=1, else RD_ADDR.
REQ-016 In WR_ADDR_DATA, SHALL assert aw_valid and w_valid in the cycle after grant.
REQ-017 SHALL drop aw_valid and w_valid independently on their respective handshakes, and enter WR_RESP once both have completed, whether they complete in the same cycle or in any order.
REQ-018 SHALL hold b_ready=1 only in WR_RESP; on the b handshake SHALL capture resp_err = (b_resp != 0) and enter RESP.
REQ-019 In RD_ADDR, SHALL hold ar_valid=1 until ar_ready, then enter RD_DATA.
REQ-020 In RD_DATA, SHALL hold r_ready=1; on r_valid SHALL capture r_data, and resp_err = (r_resp != 0) OR NOT r_last, then enter RESP.
REQ-021 In RESP, SHALL pulse resp_valid_o of the granted core for one cycle with rdata/err stable, then return to IDLE; a new grant is possible in the following cycle.
REQ-022 SHALL hold resp_rdata_o at 0 for writes.
REQ-023 SHALL drive addr = CLINT_BASE + zero-extended offset, len=0, size=3'b011, burst=INCR, strb=8'hFF, last=1, and id = granted index.
REQ-024 SHALL keep all AXI valid and address fields stable while valid is asserted and ready is low.
REQ-025 SHALL permit at most one outstanding transaction, with no timeout.
REQ-026 SHALL ignore requests that arrive while not in IDLE; they remain pending.

Reset
REQ-027 On ndmreset_n low, at any time including mid-transaction, SHALL immediately force all valid/ready outputs to 0, state to IDLE, round-robin pointer to 0, and rdata/err to 0.
REQ-028 SHALL NOT complete an interrupted transaction after reset release.

Structure
REQ-029 SHALL place the FSM state enum and the default CLINT_BASE constant in shared package clint_pkg.
REQ-030 SHALL implement round-robin selection in sub-module rr_arbiter (inputs: req vector, pointer; outputs: one-hot grant, index).

Verification
REQ-031 Bench SHALL check: core0 write off 16'h4000, data 64'h1234, aw/w ready=1 same cycle, b_resp=0 -> aw_addr 64'h0200_4000, id 0, resp_valid_o=2'b01 with err 0, 3 cycles after grant.
REQ-032 Bench SHALL check: core1 read off 16'hBFF8, r_data 64'hDEAD, r_resp=0, r_last=1 -> resp_valid_o=2'b10, resp_rdata_o=64'hDEAD, err=0.
REQ-033 Bench SHALL check: both cores valid continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-034 Bench SHALL check: w_ready 3 cycles after aw_ready -> aw_valid drops after 1 cycle, w_valid held until its handshake, then a single b handshake.
REQ-035 Bench SHALL check: b_resp=2'b10 -> resp_err_o=1; separately, r_last=0 on a read -> resp_err_o=1.
REQ-036 Bench SHALL check: reset asserted in WR_RESP -> all valids 0 the same cycle, no resp_valid_o after release, next grant goes to core0.
